// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: FIFO-buffered UART transmitter whose framing (bit time, data length,
// parity, stop bits) is latched per frame at pop time; tx, busy and tx_done are registered.
module uart_tx_gen2 #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       length,
  input  logic             parity_en,
  input  logic             parity_type,
  input  logic             stop2,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             tx_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_W'(2)) begin
      return DIV_W'(2);
    end else begin
      return d;
    end
  endfunction

  function automatic logic [3:0] sanitize_len(input logic [3:0] l);
    if ((l >= 4'd5) && (l <= 4'd8)) begin
      return l;
    end else begin
      return 4'd8;
    end
  endfunction

  // Parity over the low l data bits only; even = XOR, odd = inverted XOR.
  function automatic logic calc_parity(input logic [7:0] d, input logic [3:0] l, input logic even);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(l)) begin
        acc = acc ^ d[i];
      end
    end
    return even ? acc : ~acc;
  endfunction

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             wr_ready_r;
  logic             wr_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             err_r;
  logic [7:0]       head_s;

  state_t           state_r;
  state_t           state_s;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_s;
  logic [2:0]       idx_r;
  logic [2:0]       idx_s;
  logic             bit_end_s;
  logic             last_stop_s;

  logic [7:0]       data_r;
  logic [DIV_W-1:0] div_r;
  logic [3:0]       len_r;
  logic             par_en_r;
  logic             par_bit_r;
  logic             stop2_r;

  logic             tx_r;
  logic             tx_s;
  logic             busy_r;
  logic             done_r;
  logic             done_s;

  assign head_s = mem_r[rd_ptr_r];

  // FIFO handshake; ready is derived from the next occupancy so it never allows write-through
  always_comb begin
    push_s     = wr_valid && wr_ready_r;
    count_s    = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    wr_ready_s = (count_s != CNT_W'(FIFO_DEPTH));
  end

  // FIFO storage, no reset needed because pointers and count define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      wr_ready_r <= 1'b1;
      err_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_s;
      wr_ready_r <= wr_ready_s;
      if (wr_valid && !wr_ready_r) begin
        err_r <= 1'b1;
      end
    end
  end

  // Next state, baud counter, bit index and registered-output lookahead
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    pop_s       = 1'b0;
    tx_s        = 1'b1;
    done_s      = 1'b0;
    bit_end_s   = (cnt_r == (div_r - DIV_W'(1)));
    last_stop_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        cnt_s = '0;
        idx_s = '0;
        if (count_r != '0) begin
          pop_s   = 1'b1;
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          idx_s   = '0;
          state_s = S_DATA;
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_s = '0;
          if ({1'b0, idx_r} == (len_r - 4'd1)) begin
            idx_s   = '0;
            state_s = par_en_r ? S_PARITY : S_STOP1;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          state_s = S_STOP1;
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end
      S_STOP1: begin
        if (bit_end_s) begin
          cnt_s = '0;
          if (stop2_r) begin
            state_s = S_STOP2;
          end else begin
            last_stop_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end
      S_STOP2: begin
        if (bit_end_s) begin
          cnt_s       = '0;
          last_stop_s = 1'b1;
        end else begin
          cnt_s = cnt_r + DIV_W'(1);
        end
      end
      default: begin
        cnt_s   = '0;
        idx_s   = '0;
        state_s = S_IDLE;
      end
    endcase

    // End of the final stop bit chains straight into the next queued frame.
    if (last_stop_s) begin
      if (count_r != '0) begin
        pop_s   = 1'b1;
        state_s = S_START;
      end else begin
        state_s = S_IDLE;
      end
    end else begin
      pop_s = pop_s;
    end

    case (state_s)
      S_START:  tx_s = 1'b0;
      S_DATA:   tx_s = data_r[idx_s];
      S_PARITY: tx_s = par_bit_r;
      default:  tx_s = 1'b1;
    endcase

    if (((state_s == S_STOP2) || ((state_s == S_STOP1) && !stop2_r)) &&
        (cnt_s == (div_r - DIV_W'(1)))) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= done_s;
    end
  end

  // Per-frame configuration captured at pop so mid-frame input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= 8'h00;
      div_r     <= DIV_W'(2);
      len_r     <= 4'd8;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
    end else if (pop_s) begin
      data_r    <= head_s;
      div_r     <= clamp_div(baud_div);
      len_r     <= sanitize_len(length);
      par_en_r  <= parity_en;
      par_bit_r <= calc_parity(head_s, sanitize_len(length), parity_type);
      stop2_r   <= stop2;
    end
  end

  assign wr_ready   = wr_ready_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign tx_done    = done_r;
  assign fifo_count = count_r;
  assign tx_err     = err_r;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Self-checking bench for uart_tx_gen2: logs tx/tx_done/busy/fifo_count every cycle and
// compares the log against frames built from the framing rules with plain arithmetic.
module tb_uart_tx_gen2;

  localparam int DIV_W = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int LOGN  = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] baud_div;
  logic [3:0]       length;
  logic             parity_en;
  logic             parity_type;
  logic             stop2;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             tx;
  logic             busy;
  logic             tx_done;
  logic [CNT_W-1:0] fifo_count;
  logic             tx_err;

  uart_tx_gen2 #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .length(length),
    .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         div;
    int         len;
    bit         pen;
    bit         pty;
    bit         st2;
  } frame_t;

  frame_t     exp_q[$];
  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  logic       txlog   [0:LOGN-1];
  logic       donelog [0:LOGN-1];
  logic       busylog [0:LOGN-1];
  logic [3:0] cntlog  [0:LOGN-1];

  // Each call advances to the next falling edge and records the cycle's outputs.
  task automatic tick();
    @(negedge clk);
    if (cyc < LOGN) begin
      txlog[cyc]   = tx;
      donelog[cyc] = tx_done;
      busylog[cyc] = busy;
      cntlog[cyc]  = fifo_count;
    end
    cyc = cyc + 1;
  endtask

  task automatic run_to(input int t);
    while (cyc <= t) tick();
  endtask

  task automatic set_cfg(input int d, input int l, input bit pe, input bit pt, input bit s2);
    baud_div    = DIV_W'(d);
    length      = 4'(l);
    parity_en   = pe;
    parity_type = pt;
    stop2       = s2;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  function automatic frame_t mk_frame(input logic [7:0] d, input int raw_div, input int raw_len,
                                      input bit pe, input bit pt, input bit s2);
    frame_t f;
    f.d   = d;
    f.div = (raw_div < 2) ? 2 : raw_div;
    f.len = (raw_len >= 5 && raw_len <= 8) ? raw_len : 8;
    f.pen = pe;
    f.pty = pt;
    f.st2 = s2;
    return f;
  endfunction

  function automatic int frame_cycles(input frame_t f);
    return (1 + f.len + int'(f.pen) + 1 + int'(f.st2)) * f.div;
  endfunction

  // Serial bit k of a frame: start, data LSB first, optional parity, stop bits.
  function automatic logic frame_bit(input frame_t f, input int k);
    logic p;
    if (k == 0) return 1'b0;
    if (k <= f.len) return f.d[k-1];
    if (f.pen && k == f.len + 1) begin
      p = 1'b0;
      for (int j = 0; j < f.len; j++) p = p ^ f.d[j];
      return f.pty ? p : ~p;
    end
    return 1'b1;
  endfunction

  function automatic int queued_cycles();
    int s;
    s = 0;
    for (int k = 0; k < exp_q.size(); k++) s = s + frame_cycles(exp_q[k]);
    return s;
  endfunction

  // Expected frames are contiguous from 'start'; afterwards the line must be idle.
  task automatic check_stream(input int start, input string name);
    int           off;
    int           n;
    frame_t       f;
    logic [127:0] e_tx, o_tx, e_dn, o_dn, e_bs, o_bs;
    off = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      f = exp_q[k];
      n = frame_cycles(f);
      e_tx = '0; o_tx = '0; e_dn = '0; o_dn = '0; e_bs = '0; o_bs = '0;
      for (int i = 0; i < n; i++) begin
        e_tx[i] = frame_bit(f, i / f.div);
        e_dn[i] = (i == n - 1);
        e_bs[i] = 1'b1;
        o_tx[i] = txlog[start + off + i];
        o_dn[i] = donelog[start + off + i];
        o_bs[i] = busylog[start + off + i];
      end
      total++;
      if (o_tx !== e_tx) $display("FAIL %s frame%0d tx: got %h expected %h", name, k, o_tx, e_tx);
      else passed++;
      total++;
      if (o_dn !== e_dn) $display("FAIL %s frame%0d tx_done: got %h expected %h", name, k, o_dn, e_dn);
      else passed++;
      total++;
      if (o_bs !== e_bs) $display("FAIL %s frame%0d busy: got %h expected %h", name, k, o_bs, e_bs);
      else passed++;
      off = off + n;
    end
    total++;
    if ({txlog[start + off], busylog[start + off], donelog[start + off]} !== 3'b100)
      $display("FAIL %s idle_after tx/busy/done: got %b%b%b expected 100", name,
               txlog[start + off], busylog[start + off], donelog[start + off]);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (tx !== 1'b1) $display("FAIL reset tx: got %b expected 1", tx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
    total++; if (tx_done !== 1'b0) $display("FAIL reset tx_done: got %b expected 0", tx_done); else passed++;
    total++; if (tx_err !== 1'b0) $display("FAIL reset tx_err: got %b expected 0", tx_err); else passed++;
    total++; if (fifo_count !== 4'd0) $display("FAIL reset fifo_count: got %0d expected 0", fifo_count); else passed++;
    total++; if (wr_ready !== 1'b1) $display("FAIL reset wr_ready: got %b expected 1", wr_ready); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_8n1();
    int n;
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    tick();
    n = cyc - 1;
    write_byte(8'hA5);
    exp_q.push_back(mk_frame(8'hA5, 4, 8, 1'b0, 1'b0, 1'b0));
    total++; if (fifo_count !== 4'd1) $display("FAIL 8n1 count_at_N+1: got %0d expected 1", fifo_count); else passed++;
    total++; if (tx !== 1'b1) $display("FAIL 8n1 tx_at_N+1: got %b expected 1", tx); else passed++;
    tick();
    total++; if (fifo_count !== 4'd0) $display("FAIL 8n1 count_after_pop: got %0d expected 0", fifo_count); else passed++;
    run_to(n + 2 + queued_cycles() + 1);
    check_stream(n + 2, "8n1");
  endtask

  task automatic test_7e2();
    int n;
    int ones;
    for (int pt = 1; pt >= 0; pt--) begin
      set_cfg(3, 7, 1'b1, pt[0], 1'b1);
      tick();
      n = cyc - 1;
      write_byte(8'h41);
      exp_q.push_back(mk_frame(8'h41, 3, 7, 1'b1, pt[0], 1'b1));
      run_to(n + 2 + 40);
      ones = 0;
      for (int i = n; i < n + 40; i++) ones = ones + int'(busylog[i]);
      total++;
      if (ones != 33) $display("FAIL 7x2 pty%0d frame_cycles: got %0d expected 33", pt, ones);
      else passed++;
      check_stream(n + 2, (pt == 1) ? "7e2" : "7o2");
    end
  endtask

  task automatic test_5o1();
    int n;
    set_cfg(4, 5, 1'b1, 1'b0, 1'b0);
    tick();
    n = cyc - 1;
    write_byte(8'hFF);
    exp_q.push_back(mk_frame(8'hFF, 4, 5, 1'b1, 1'b0, 1'b0));
    run_to(n + 2 + queued_cycles() + 1);
    check_stream(n + 2, "5o1");
  endtask

  task automatic test_random();
    int         n, rd, rl, nb;
    bit         pe, pt, s2;
    logic [7:0] d;
    for (int it = 0; it < 8; it++) begin
      rd = $urandom_range(0, 6);
      rl = $urandom_range(0, 15);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      set_cfg(rd, rl, pe, pt, s2);
      tick();
      n = cyc - 1;
      for (int b = 0; b < nb; b++) begin
        d = 8'($urandom);
        write_byte(d);
        exp_q.push_back(mk_frame(d, rd, rl, pe, pt, s2));
      end
      run_to(n + 2 + queued_cycles() + 1);
      check_stream(n + 2, $sformatf("rand%0d", it));
    end
  endtask

  task automatic test_back_to_back();
    int         n, mcnt, start;
    logic [7:0] d;
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (tx_err !== 1'b0) $display("FAIL b2b err_before: got %b expected 0", tx_err); else passed++;
    n = cyc - 1;
    start = n + 2;
    d = 8'($urandom);
    write_byte(d);
    exp_q.push_back(mk_frame(d, 4, 8, 1'b0, 1'b0, 1'b0));
    tick();
    mcnt = 0;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (fifo_count !== 4'(mcnt)) $display("FAIL b2b count%0d: got %0d expected %0d", i, fifo_count, mcnt);
      else passed++;
      total++;
      if (wr_ready !== (mcnt < DEPTH)) $display("FAIL b2b wr_ready%0d: got %b expected %b", i, wr_ready, mcnt < DEPTH);
      else passed++;
      d = 8'($urandom);
      wr_valid = 1'b1;
      wr_data  = d;
      if (mcnt < DEPTH) begin
        exp_q.push_back(mk_frame(d, 4, 8, 1'b0, 1'b0, 1'b0));
        mcnt++;
      end
      tick();
    end
    wr_valid = 1'b0;
    total++; if (tx_err !== 1'b1) $display("FAIL b2b overflow_err: got %b expected 1", tx_err); else passed++;
    total++; if (fifo_count !== 4'd8) $display("FAIL b2b full_count: got %0d expected 8", fifo_count); else passed++;
    run_to(start + queued_cycles() + 1);
    for (int j = 1; j <= 8; j++) begin
      total++;
      if (cntlog[start + j * 40] !== 4'(8 - j))
        $display("FAIL b2b count_at_frame%0d: got %0d expected %0d", j, cntlog[start + j * 40], 8 - j);
      else passed++;
    end
    check_stream(start, "b2b");
  endtask

  task automatic test_midframe_cfg();
    int         n;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    tick();
    n = cyc - 1;
    write_byte(a);
    write_byte(b);
    exp_q.push_back(mk_frame(a, 4, 8, 1'b0, 1'b0, 1'b0));
    run_to(n + 2 + 10);
    set_cfg(8, 5, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk_frame(b, 8, 5, 1'b0, 1'b0, 1'b0));
    run_to(n + 2 + queued_cycles() + 1);
    check_stream(n + 2, "midcfg");
  endtask

  task automatic test_reset_clamp();
    int         n, r0, bad;
    logic [7:0] d;
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    tick();
    n = cyc - 1;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    run_to(n + 2 + 12);
    total++; if (busy !== 1'b1) $display("FAIL rstmid busy_before: got %b expected 1", busy); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (tx !== 1'b1) $display("FAIL rstmid tx: got %b expected 1", tx); else passed++;
    total++; if (fifo_count !== 4'd0) $display("FAIL rstmid fifo_count: got %0d expected 0", fifo_count); else passed++;
    total++; if (tx_err !== 1'b0) $display("FAIL rstmid tx_err: got %b expected 0", tx_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid busy: got %b expected 0", busy); else passed++;
    r0 = cyc;
    run_to(r0 + 150);
    bad = 0;
    for (int i = r0; i <= r0 + 150; i++) if (txlog[i] !== 1'b1 || busylog[i] !== 1'b0) bad++;
    total++; if (bad != 0) $display("FAIL rstmid residual_cycles: got %0d expected 0", bad); else passed++;
    set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
    tick();
    n = cyc - 1;
    d = 8'($urandom);
    write_byte(d);
    exp_q.push_back(mk_frame(d, 0, 8, 1'b0, 1'b0, 1'b0));
    run_to(n + 2 + queued_cycles() + 1);
    check_stream(n + 2, "clamp0");
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_random();
    test_back_to_back();
    test_midframe_cfg();
    test_reset_clamp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
